// File: rtl/voice_pkg.sv
// Shared constants, types and helpers for the voice RAM path (recorder and playback).
package voice_pkg;

   localparam int unsigned CHUNKS          = 2830;
   localparam int unsigned CLKS_PER_SAMPLE = 300;
   localparam int unsigned SAMPLE_W        = 8;
   localparam int unsigned ADDR_W          = 12;
   localparam int unsigned WORD_W          = 4 * SAMPLE_W;

   localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 8'h80;

   typedef enum logic [1:0] {PB_IDLE, PB_PRIME, PB_PLAY} pb_state_t;

   // Sample k of a packed word; k=0 sits in the low byte and plays first.
   function automatic logic [SAMPLE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                     input logic [1:0]        k);
      return w[SAMPLE_W*k +: SAMPLE_W];
   endfunction

endpackage

// File: rtl/voice_playback_if.sv
// Control, RAM read and audio signals of the playback block, bundled for connection.
interface voice_playback_if;
   import voice_pkg::*;

   logic                start;
   logic                stop;
   logic                ram_rd;
   logic [ADDR_W-1:0]   ram_addr;
   logic [WORD_W-1:0]   ram_data;
   logic                busy;
   logic                done;
   logic [SAMPLE_W-1:0] sample_out;
   logic                audio_en;
   logic                audio_out;

   modport slave (
      input  start, stop, ram_data,
      output ram_rd, ram_addr, busy, done, sample_out, audio_en, audio_out
   );

   modport master (
      output start, stop, ram_data,
      input  ram_rd, ram_addr, busy, done, sample_out, audio_en, audio_out
   );

endinterface

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: ones density of bit_out tracks sample/256.
module sigma_delta_dac
   import voice_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [SAMPLE_W-1:0] sample,
   output logic                bit_out
);

   logic [SAMPLE_W-1:0] acc;
   logic [SAMPLE_W:0]   sum;

   // Only the low bits persist; the carry out of the sum is the output bit itself.
   assign sum = {1'b0, acc} + {1'b0, sample};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         bit_out <= 1'b0;
      end else if (en) begin
         acc     <= sum[SAMPLE_W-1:0];
         bit_out <= sum[SAMPLE_W];
      end else begin
         acc     <= '0;
         bit_out <= 1'b0;
      end
   end

endmodule

// File: rtl/voice_playback.sv
// Voice playback: streams packed PCM words from RAM, holds each byte one sample period
// and feeds it to the sigma-delta DAC.
module voice_playback #(
   parameter int unsigned CHUNKS          = voice_pkg::CHUNKS,
   parameter int unsigned CLKS_PER_SAMPLE = voice_pkg::CLKS_PER_SAMPLE
) (
   input  logic             clk,
   input  logic             rst,
   voice_playback_if.slave  pb
);

   localparam int unsigned WW    = voice_pkg::WORD_W;
   localparam int unsigned CNT_W = $clog2(CLKS_PER_SAMPLE);

   voice_pkg::pb_state_t state;
   logic [CNT_W-1:0]     smp_cnt;
   logic [1:0]           byte_idx;
   logic [WW-1:0]        cur_word;
   logic [WW-1:0]        nxt_word;
   logic                 rd_pend;
   logic                 have_nxt;
   logic                 terminal;
   logic                 more_words;

   assign terminal    = (smp_cnt == CNT_W'(CLKS_PER_SAMPLE - 1));
   assign more_words  = (32'(pb.ram_addr) + 32'd1) < CHUNKS;
   assign pb.audio_en = pb.busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= voice_pkg::PB_IDLE;
         pb.ram_rd     <= 1'b0;
         pb.ram_addr   <= '0;
         pb.busy       <= 1'b0;
         pb.done       <= 1'b0;
         pb.sample_out <= voice_pkg::SAMPLE_MID;
         smp_cnt       <= '0;
         byte_idx      <= '0;
         cur_word      <= '0;
         nxt_word      <= '0;
         rd_pend       <= 1'b0;
         have_nxt      <= 1'b0;
      end else begin
         pb.ram_rd <= 1'b0;
         pb.done   <= 1'b0;
         rd_pend   <= pb.ram_rd;
         // Abort has priority over everything, including the natural end of playback.
         if (state != voice_pkg::PB_IDLE && pb.stop) begin
            state         <= voice_pkg::PB_IDLE;
            pb.busy       <= 1'b0;
            pb.sample_out <= voice_pkg::SAMPLE_MID;
            smp_cnt       <= '0;
            byte_idx      <= '0;
            rd_pend       <= 1'b0;
            have_nxt      <= 1'b0;
         end else begin
            unique case (state)
               voice_pkg::PB_IDLE: begin
                  if (pb.start && !pb.stop) begin
                     state       <= voice_pkg::PB_PRIME;
                     pb.ram_rd   <= 1'b1;
                     pb.ram_addr <= '0;
                     pb.busy     <= 1'b1;
                  end
               end
               voice_pkg::PB_PRIME: begin
                  if (rd_pend) begin
                     state         <= voice_pkg::PB_PLAY;
                     cur_word      <= pb.ram_data;
                     pb.sample_out <= voice_pkg::word_byte(pb.ram_data, 2'd0);
                     smp_cnt       <= '0;
                     byte_idx      <= '0;
                     have_nxt      <= 1'b0;
                  end
               end
               voice_pkg::PB_PLAY: begin
                  if (rd_pend) nxt_word <= pb.ram_data;
                  // Prefetch early in the last byte so the next word is ready with no gap.
                  if (byte_idx == 2'd3 && smp_cnt == '0 && more_words) begin
                     pb.ram_rd   <= 1'b1;
                     pb.ram_addr <= pb.ram_addr + 1'b1;
                     have_nxt    <= 1'b1;
                  end
                  if (terminal) begin
                     smp_cnt  <= '0;
                     byte_idx <= byte_idx + 2'd1;
                     if (byte_idx != 2'd3) begin
                        pb.sample_out <= voice_pkg::word_byte(cur_word, byte_idx + 2'd1);
                     end else if (have_nxt) begin
                        cur_word      <= nxt_word;
                        pb.sample_out <= voice_pkg::word_byte(nxt_word, 2'd0);
                        have_nxt      <= 1'b0;
                     end else begin
                        state         <= voice_pkg::PB_IDLE;
                        pb.busy       <= 1'b0;
                        pb.done       <= 1'b1;
                        pb.sample_out <= voice_pkg::SAMPLE_MID;
                     end
                  end else begin
                     smp_cnt <= smp_cnt + CNT_W'(1);
                  end
               end
               default: state <= voice_pkg::PB_IDLE;
            endcase
         end
      end
   end

   sigma_delta_dac u_dac (
      .clk     (clk),
      .rst     (rst),
      .en      (pb.busy),
      .sample  (pb.sample_out),
      .bit_out (pb.audio_out)
   );

endmodule
